// File: rtl/double_tokens.sv
// double_tokens
//   Serial token doubler. Every '1' sampled on a is owed twice on b. b emits
//   at most one token per cycle. Tokens not yet emitted sit in a saturating
//   pending counter. Tokens that would push the counter past MAX are dropped,
//   and the sticky overflow flag records that this happened.
//
// Ports
//   clk      clock, all state updates on posedge
//   rst      asynchronous active-low reset
//   a        input token, sampled every cycle, never back-pressured
//   a_ready  advisory: room for two more tokens (pending <= MAX-2)
//   b        output token valid (combinational from a for zero latency)
//   b_ready  downstream accepts b this cycle
//   pending  registered count of tokens owed
//   overflow sticky flag: tokens were lost to saturation
//   ovf_clr  synchronous clear of overflow (a new saturation takes priority)
module double_tokens #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  output logic             a_ready,
  output logic             b,
  input  logic             b_ready,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam logic [CNT_W:0] MAX   = {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W:0] LIMIT = MAX - (CNT_W+1)'(2);

  logic [CNT_W-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             take;
  logic [CNT_W:0]   nxt;
  logic             sat;

  // While in reset pending_q is already 0, so b follows a and a_ready is 1
  // with no special casing.
  assign b        = a | (pending_q != '0);
  assign take     = b & b_ready;
  assign a_ready  = ({1'b0, pending_q} <= LIMIT);
  assign pending  = pending_q;
  assign overflow = overflow_q;

  always_comb begin
    // One extra bit keeps pending + 2 from wrapping. The sum cannot go
    // negative, because take implies that pending is non-zero or a is 1.
    nxt        = {1'b0, pending_q} + {{(CNT_W-1){1'b0}}, a, 1'b0}
               - {{CNT_W{1'b0}}, take};
    sat        = (nxt > MAX);
    pending_d  = sat ? MAX[CNT_W-1:0] : nxt[CNT_W-1:0];
    overflow_d = overflow_q;
    if (sat)          overflow_d = 1'b1;   // a new drop beats the clear
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_double_tokens.sv
// Scoreboarded bench for double_tokens. The driver applies inputs on negedge.
// A token-ledger model (owed count with saturation and a drop tally) pushes
// the expected outputs for that cycle. A monitor pops and compares them
// shortly after the negedge.
module tb_double_tokens;
  localparam int CNT_W = 4;
  localparam int MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, a, a_ready, b, b_ready, overflow, ovf_clr;
  logic [CNT_W-1:0] pending;

  double_tokens #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .a(a), .a_ready(a_ready), .b(b), .b_ready(b_ready),
    .pending(pending), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tid;
    bit eb;
    bit ear;
    int epend;
    bit eovf;
    bit rnd;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   owed = 0;        // tokens owed to downstream
  int   dsc = 0;         // tokens dropped since the last effective clear
  int   tok_in = 0, dropped = 0, emitted = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus, with the model update for that cycle.
  task automatic cyc(int tid, bit ai, bit bri, bit clri, bit rnd);
    exp_t e;
    int   n, drop;
    bit   eb, take;
    @(negedge clk);
    a = ai; b_ready = bri; ovf_clr = clri;
    eb      = ai || (owed > 0);
    e.tid   = tid;
    e.eb    = eb;
    e.ear   = (MAX - owed) >= 2;
    e.epend = owed;
    e.eovf  = dsc > 0;
    e.rnd   = rnd;
    q.push_back(e);
    take = eb && bri;
    n    = owed + 2 * int'(ai) - int'(take);
    drop = 0;
    if (n > MAX) begin
      drop = n - MAX;
      n    = MAX;
    end
    owed = n;
    dsc += drop;
    if (drop == 0 && clri) dsc = 0;
    if (rnd) begin
      tok_in  += int'(ai);
      dropped += drop;
    end
  endtask

  // Monitor: compares each cycle's outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("t%0d_b", e.tid),        int'(b),        int'(e.eb));
        chk($sformatf("t%0d_a_ready", e.tid),  int'(a_ready),  int'(e.ear));
        chk($sformatf("t%0d_pending", e.tid),  int'(pending),  e.epend);
        chk($sformatf("t%0d_overflow", e.tid), int'(overflow), int'(e.eovf));
        if (e.rnd && b && b_ready) emitted++;
      end
    end
  end

  initial begin
    bit [15:0] pat;
    pat = 16'b1100_1110_1000_1111;
    rst = 1'b0; a = 1'b0; b_ready = 1'b1; ovf_clr = 1'b0;
    #1;
    chk("por_pending", int'(pending), 0);
    chk("por_overflow", int'(overflow), 0);
    chk("por_b", int'(b), 0);
    chk("por_a_ready", int'(a_ready), 1);
    #11 rst = 1'b1;

    // Single token.
    cyc(2, 1, 1, 0, 0);
    repeat (3) cyc(2, 0, 1, 0, 0);

    // Bursty pattern: 10 tokens in, 20 consecutive tokens out.
    for (int i = 15; i >= 0; i--) cyc(3, pat[i], 1, 0, 0);
    repeat (6) cyc(3, 0, 1, 0, 0);

    // Reach pending=5 mid-drain, then assert asynchronous reset between edges.
    repeat (3) cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    chk("pre_reset_pending", int'(pending), owed);
    #1 rst = 1'b0;
    a = 1'b0;
    #1;
    chk("async_rst_pending", int'(pending), 0);
    chk("async_rst_overflow", int'(overflow), 0);
    chk("async_rst_b", int'(b), 0);
    chk("async_rst_a_ready", int'(a_ready), 1);
    owed = 0; dsc = 0;
    #3 rst = 1'b1;

    // Stall to saturation, then drain and clear.
    repeat (8) cyc(4, 1, 0, 0, 0);
    repeat (16) cyc(5, 0, 1, 0, 0);
    cyc(5, 0, 1, 1, 0);
    cyc(5, 0, 1, 0, 0);
    // Saturation on the same cycle as ovf_clr: the set wins.
    repeat (7) cyc(5, 1, 0, 0, 0);
    cyc(5, 1, 0, 1, 0);
    cyc(5, 0, 0, 0, 0);
    repeat (16) cyc(5, 0, 1, 0, 0);
    cyc(5, 0, 1, 1, 0);

    // Random traffic with token accounting.
    for (int i = 0; i < 10000; i++)
      cyc(6, $urandom_range(99) < 60, $urandom_range(99) < 50,
          $urandom_range(99) < 3, 1);
    repeat (20) cyc(6, 0, 1, 0, 1);

    repeat (3) @(negedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    chk("token_balance", emitted, 2 * tok_in - dropped);
    chk("final_pending", int'(pending), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
